// File: rtl/midi_tx_fifo.sv
// Byte FIFO between the MIDI router core and the UART transmit controller.
// Non-show-ahead registered read port, occupancy level and sticky overflow/underflow flags.
module midi_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              flush,
  input  logic              fifo_rd,
  output logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_empty_n,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_cnt;
  logic [WIDTH-1:0]  r_data;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_afull;
  logic w_nempty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_evt;
  logic w_udf_evt;

  always_comb begin
    w_full    = (r_cnt == (ADDR_W+1)'(DEPTH));
    w_afull   = (r_cnt >= (ADDR_W+1)'(AFULL_LVL));
    w_nempty  = (r_cnt != '0);
    // A flush cycle ignores both requests, so it neither moves data nor raises errors
    w_wr_acc  = wr_en   & ~w_full   & ~flush;
    w_rd_acc  = fifo_rd & w_nempty  & ~flush;
    w_ovf_evt = wr_en   & w_full    & ~flush;
    w_udf_evt = fifo_rd & ~w_nempty & ~flush;
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_data <= r_mem[r_rptr];
        r_rptr <= r_rptr + ADDR_W'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + (ADDR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (ADDR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Clear first, then a same-cycle error event overrides it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (err_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
      if (w_udf_evt) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign full         = w_full;
  assign almost_full  = w_afull;
  assign fifo_empty_n = w_nempty;
  assign level        = r_cnt;
  assign fifo_data    = r_data;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_midi_tx_fifo.sv
// Directed self-checking bench for midi_tx_fifo (default parameters, depth 16).
module tb_midi_tx_fifo;

  logic       rst;
  logic       clk;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       almost_full;
  logic       flush;
  logic       fifo_rd;
  logic [7:0] fifo_data;
  logic       fifo_empty_n;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  midi_tx_fifo #(.WIDTH(8), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .rst          (rst),
    .clk          (clk),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .flush        (flush),
    .fifo_rd      (fifo_rd),
    .fifo_data    (fifo_data),
    .fifo_empty_n (fifo_empty_n),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pop();
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] held;
  int nw;
  int nr;
  logic do_wr;
  logic do_rd;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_nempty", 32'(fifo_empty_n), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    rst = 1'b0;

    // Three bytes in, three pops out
    push(8'h90);
    chk("wr1_nempty", 32'(fifo_empty_n), 32'd1);
    chk("wr1_level", 32'(level), 32'd1);
    push(8'h3C);
    push(8'h64);
    chk("wr3_level", 32'(level), 32'd3);
    pop();
    chk("pop1_data", 32'(fifo_data), 32'h90);
    pop();
    chk("pop2_data", 32'(fifo_data), 32'h3C);
    chk("pop2_nempty", 32'(fifo_empty_n), 32'd1);
    pop();
    chk("pop3_data", 32'(fifo_data), 32'h64);
    chk("pop3_nempty", 32'(fifo_empty_n), 32'd0);
    chk("pop3_level", 32'(level), 32'd0);
    tick();
    chk("data_hold", 32'(fifo_data), 32'h64);

    // Fill to full, overflow attempt, drain
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end
    chk("fill_ovf_clear", 32'(overflow), 32'd0);
    push(8'hFF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("drain_data", 32'(fifo_data), 32'(i));
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_ovf", 32'(overflow), 32'd0);

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    chk("full2", 32'(full), 32'd1);
    wr_en = 1'b1; wr_data = 8'hEE; fifo_rd = 1'b1;
    tick();
    wr_en = 1'b0; fifo_rd = 1'b0;
    chk("fullrw_level", 32'(level), 32'd15);
    chk("fullrw_ovf", 32'(overflow), 32'd1);
    chk("fullrw_data", 32'(fifo_data), 32'hA0);
    chk("fullrw_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      pop();
      chk("fullrw_drain", 32'(fifo_data), 32'hA0 + 32'(i));
    end
    chk("fullrw_empty", 32'(fifo_empty_n), 32'd0);
    wr_en = 1'b1; wr_data = 8'h55; fifo_rd = 1'b1;
    tick();
    wr_en = 1'b0; fifo_rd = 1'b0;
    chk("emptyrw_level", 32'(level), 32'd1);
    chk("emptyrw_udf", 32'(underflow), 32'd1);
    chk("emptyrw_data", 32'(fifo_data), 32'hAF);
    pop();
    chk("emptyrw_pop", 32'(fifo_data), 32'h55);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr2_ovf", 32'(overflow), 32'd0);
    chk("errclr2_udf", 32'(underflow), 32'd0);

    // err_clr together with a new underflow: set wins
    pop();
    chk("udf_set", 32'(underflow), 32'd1);
    err_clr = 1'b1; fifo_rd = 1'b1;
    tick();
    err_clr = 1'b0; fifo_rd = 1'b0;
    chk("setwins_udf", 32'(underflow), 32'd1);
    chk("setwins_data", 32'(fifo_data), 32'h55);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_udf", 32'(underflow), 32'd0);

    // 40-byte stream with interleaved reads against a queue model
    q.delete();
    nw = 0;
    nr = 0;
    for (int c = 0; c < 400 && nr < 40; c++) begin
      do_wr = (nw < 40) && (q.size() < 5) && (c % 5 != 4);
      do_rd = (q.size() >= 3) || ((c % 2 == 1) && (q.size() > 0)) || ((nw == 40) && (q.size() > 0));
      wr_en   = do_wr;
      wr_data = 8'(nw * 13 + 5);
      fifo_rd = do_rd;
      tick();
      wr_en = 1'b0; fifo_rd = 1'b0;
      if (do_rd) begin
        exp_d = q.pop_front();
        nr++;
        chk("stream_data", 32'(fifo_data), 32'(exp_d));
      end
      if (do_wr) begin
        q.push_back(8'(nw * 13 + 5));
        nw++;
      end
      chk("stream_level", 32'(level), 32'(q.size()));
    end
    chk("stream_count", 32'(nr), 32'd40);

    // Flush with a concurrent write
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
    chk("pre_flush_level", 32'(level), 32'd7);
    held = fifo_data;
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_nempty", 32'(fifo_empty_n), 32'd0);
    chk("flush_data", 32'(fifo_data), 32'(held));
    push(8'h12);
    pop();
    chk("post_flush_data", 32'(fifo_data), 32'h12);

    // Asynchronous reset mid-stream with both flags set and level 9
    pop();
    chk("pre_rst_udf", 32'(underflow), 32'd1);
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    push(8'hDD);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 7; i++) pop();
    chk("pre_rst_level", 32'(level), 32'd9);
    chk("pre_rst_data", 32'(fifo_data), 32'hC6);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_nempty", 32'(fifo_empty_n), 32'd0);
    chk("arst_data", 32'(fifo_data), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_udf", 32'(underflow), 32'd0);
    tick();
    rst = 1'b0;
    push(8'h4B);
    chk("post_rst_level", 32'(level), 32'd1);
    pop();
    chk("post_rst_data", 32'(fifo_data), 32'h4B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
